// File: rtl/sequenciador_exibicao.sv
`default_nettype none
// sequenciador_exibicao: plays back the stored colour sequence, from RAM address 0
// up to the latched round, lighting each colour for a difficulty-dependent time followed by a dark gap.
module sequenciador_exibicao #(
  parameter int T_ACESO_FACIL   = 1000,
  parameter int T_ACESO_DIFICIL = 500,
  parameter int T_APAGADO       = 250,
  parameter int W_TEMPO         = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar_exibicao,
  input  logic       cancela,
  input  logic [3:0] rodada,
  input  logic       dificil,
  input  logic [3:0] dado_ram,
  output logic [3:0] endereco,
  output logic [3:0] leds,
  output logic       exibindo,
  output logic       fim_exibicao,
  output logic [2:0] db_estado
);

  localparam logic [2:0] OCIOSO  = 3'd0;
  localparam logic [2:0] CARREGA = 3'd1;
  localparam logic [2:0] ACESO   = 3'd2;
  localparam logic [2:0] APAGADO = 3'd3;
  localparam logic [2:0] FIM     = 3'd4;

  localparam logic [W_TEMPO-1:0] ULT_FACIL   = W_TEMPO'(T_ACESO_FACIL - 1);
  localparam logic [W_TEMPO-1:0] ULT_DIFICIL = W_TEMPO'(T_ACESO_DIFICIL - 1);
  localparam logic [W_TEMPO-1:0] ULT_APAGADO = W_TEMPO'(T_APAGADO - 1);

  logic [2:0]         estado;
  logic [W_TEMPO-1:0] timer;
  logic [3:0]         r_cor;
  logic [3:0]         r_lim;
  logic               r_dif;
  logic               fim_aceso;
  logic               fim_apagado;

  assign fim_aceso   = (timer == (r_dif ? ULT_DIFICIL : ULT_FACIL));
  assign fim_apagado = (timer == ULT_APAGADO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado   <= OCIOSO;
      timer    <= '0;
      endereco <= 4'd0;
      leds     <= 4'd0;
      r_cor    <= 4'd0;
      r_lim    <= 4'd0;
      r_dif    <= 1'b0;
    end else if (cancela) begin
      estado   <= OCIOSO;
      timer    <= '0;
      endereco <= 4'd0;
      leds     <= 4'd0;
    end else begin
      case (estado)
        OCIOSO: begin
          endereco <= 4'd0;
          leds     <= 4'd0;
          if (iniciar_exibicao) begin
            r_lim  <= rodada;
            r_dif  <= dificil;
            timer  <= '0;
            estado <= CARREGA;
          end
        end
        CARREGA: begin
          // leds loads the same registered sample as r_cor so it is valid on the first ACESO cycle
          r_cor  <= dado_ram;
          leds   <= dado_ram;
          timer  <= '0;
          estado <= ACESO;
        end
        ACESO: begin
          if (fim_aceso) begin
            timer  <= '0;
            leds   <= 4'd0;
            estado <= APAGADO;
          end else begin
            timer <= timer + W_TEMPO'(1);
          end
        end
        APAGADO: begin
          if (fim_apagado) begin
            timer <= '0;
            if (endereco == r_lim) begin
              estado <= FIM;
            end else begin
              endereco <= endereco + 4'd1;
              estado   <= CARREGA;
            end
          end else begin
            timer <= timer + W_TEMPO'(1);
          end
        end
        FIM: begin
          endereco <= 4'd0;
          estado   <= OCIOSO;
        end
        default: begin
          estado   <= OCIOSO;
          timer    <= '0;
          endereco <= 4'd0;
          leds     <= 4'd0;
        end
      endcase
    end
  end

  assign exibindo     = (estado != OCIOSO);
  assign fim_exibicao = (estado == FIM);
  assign db_estado    = estado;

endmodule
`default_nettype wire

// File: tb/tb_sequenciador_exibicao.sv
`default_nettype none
// Testbench for sequenciador_exibicao: per-cycle comparison against an arithmetic
// model of the playback timeline.
module tb_sequenciador_exibicao;

  localparam int TF = 4;
  localparam int TD = 2;
  localparam int TA = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar_exibicao = 1'b0;
  logic       cancela = 1'b0;
  logic [3:0] rodada = 4'd0;
  logic       dificil = 1'b0;
  logic [3:0] dado_ram;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       exibindo;
  logic       fim_exibicao;
  logic [2:0] db_estado;

  logic [3:0] mem [16];
  int checks = 0;
  int errors = 0;

  sequenciador_exibicao #(
    .T_ACESO_FACIL(TF), .T_ACESO_DIFICIL(TD), .T_APAGADO(TA), .W_TEMPO(16)
  ) dut (
    .clock(clock), .reset(reset), .iniciar_exibicao(iniciar_exibicao),
    .cancela(cancela), .rodada(rodada), .dificil(dificil), .dado_ram(dado_ram),
    .endereco(endereco), .leds(leds), .exibindo(exibindo),
    .fim_exibicao(fim_exibicao), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // RAM whose data follows the registered address within the cycle
  assign dado_ram = mem[endereco];

  task automatic check_idle(input string nome);
    checks++;
    if ({leds, endereco, exibindo, fim_exibicao, db_estado} !== 13'd0) begin
      errors++;
      $display("FAIL %s: leds=%b end=%0d exib=%b fim=%b est=%0d, required all zero",
               nome, leds, endereco, exibindo, fim_exibicao, db_estado);
    end
  endtask

  // perturb: 0 none, 1 flip rodada/dificil once mid-run, 2 random every cycle
  task automatic run_check(input string nome, input int lim, input bit dif,
                           input int cancel_k, input int perturb, input bit extra_starts);
    int ton, p, total, elem, off;
    logic [3:0] e_leds, e_end;
    logic e_exib, e_fim;
    logic [2:0] e_est;
    ton = dif ? TD : TF;
    p = 1 + ton + TA;
    total = (lim + 1) * p;
    @(negedge clock);
    rodada = 4'(lim);
    dificil = dif;
    iniciar_exibicao = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= total + 3; k++) begin
      @(negedge clock);
      cancela = 1'b0;
      iniciar_exibicao = (extra_starts && k <= total + 1) ? 1'($urandom) : 1'b0;
      if (perturb == 1 && k == 5) begin
        rodada = 4'(lim + 1);
        dificil = ~dif;
      end else if (perturb == 2) begin
        rodada = 4'($urandom);
        dificil = 1'($urandom);
      end
      e_leds = 4'd0; e_end = 4'd0; e_exib = 1'b0; e_fim = 1'b0; e_est = 3'd0;
      if (cancel_k > 0 && k > cancel_k) begin
        // aborted: idle values
      end else if (k <= total) begin
        elem = (k - 1) / p;
        off = (k - 1) % p;
        e_end = 4'(elem);
        e_exib = 1'b1;
        if (off == 0) e_est = 3'd1;
        else if (off <= ton) begin
          e_est = 3'd2;
          e_leds = mem[elem];
        end else e_est = 3'd3;
      end else if (k == total + 1) begin
        e_end = 4'(lim);
        e_exib = 1'b1;
        e_fim = 1'b1;
        e_est = 3'd4;
      end
      checks++;
      if (leds !== e_leds) begin
        errors++;
        $display("FAIL %s leds cycle %0d: got %b required %b", nome, k, leds, e_leds);
      end
      checks++;
      if (endereco !== e_end) begin
        errors++;
        $display("FAIL %s endereco cycle %0d: got %0d required %0d", nome, k, endereco, e_end);
      end
      checks++;
      if (exibindo !== e_exib) begin
        errors++;
        $display("FAIL %s exibindo cycle %0d: got %b required %b", nome, k, exibindo, e_exib);
      end
      checks++;
      if (fim_exibicao !== e_fim) begin
        errors++;
        $display("FAIL %s fim_exibicao cycle %0d: got %b required %b", nome, k, fim_exibicao, e_fim);
      end
      checks++;
      if (db_estado !== e_est) begin
        errors++;
        $display("FAIL %s db_estado cycle %0d: got %0d required %0d", nome, k, db_estado, e_est);
      end
      if (k == cancel_k) cancela = 1'b1;
    end
    iniciar_exibicao = 1'b0;
    cancela = 1'b0;
    rodada = 4'd0;
    dificil = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    check_idle("reset_values");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_idle("after_reset_release");
  endtask

  task automatic test_reset_mid_aceso();
    @(negedge clock);
    rodada = 4'd1;
    dificil = 1'b0;
    iniciar_exibicao = 1'b1;
    @(posedge clock);
    #1 iniciar_exibicao = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (leds !== 4'b0001 || db_estado !== 3'd2) begin
      errors++;
      $display("FAIL reset_setup: leds=%b est=%0d required 0001/2", leds, db_estado);
    end
    #2 reset = 1'b1;
    #1 check_idle("async_reset_mid_aceso");
    @(negedge clock);
    reset = 1'b0;
    repeat (12) begin
      @(negedge clock);
      check_idle("idle_after_reset");
    end
  endtask

  task automatic test_start_with_cancel();
    @(negedge clock);
    rodada = 4'd2;
    iniciar_exibicao = 1'b1;
    cancela = 1'b1;
    @(negedge clock);
    iniciar_exibicao = 1'b0;
    cancela = 1'b0;
    repeat (3) begin
      check_idle("start_and_cancel");
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++)
      run_check("random", int'($urandom_range(0, 5)), 1'($urandom), 0, 2, 1'($urandom));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 4'b0001 << (i % 4);
    test_reset();
    test_reset_mid_aceso();
    run_check("round0_easy", 0, 1'b0, 0, 0, 1'b0);
    run_check("round2_hard", 2, 1'b1, 0, 1, 1'b0);
    run_check("cancel", 2, 1'b0, 1 + TF + TA + 2, 0, 1'b0);
    run_check("ignored_start", 2, 1'b1, 0, 0, 1'b1);
    test_start_with_cancel();
    test_random();
    run_check("max_round", 15, 1'b1, 0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
